// File: rtl/receptor_serial_if.sv
// receptor_serial_if
//   Bundle between the serial line / position consumer and the receiver.
//   canal_serial  : serial line into the receiver, idles high
//   x, y, z       : last complete position triple
//   datos_validos : one-cycle pulse when x/y/z update
//   error_trama   : one-cycle pulse on a bad stop bit
//   indice        : next byte slot expected (debug)
//   slave modport is the receiver side, master modport is the line/consumer side.
interface receptor_serial_if;
  logic       canal_serial;
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] z;
  logic       datos_validos;
  logic       error_trama;
  logic [1:0] indice;

  modport master (
    output canal_serial,
    input  x, y, z, datos_validos, error_trama, indice
  );

  modport slave (
    input  canal_serial,
    output x, y, z, datos_validos, error_trama, indice
  );
endinterface

// File: rtl/receptor_serial.sv
// receptor_serial
//   Recovers three back-to-back UART-style frames (x, y, z) from the serial
//   line and presents them as one atomic triple.
//   clk   : receiver clock, CLKS_PER_BIT x line bit rate
//   rst_n : synchronous active-low reset
//   bus   : receptor_serial_if.slave (line in, triple/pulses/indice out)
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for a falling edge; counts idle clocks for timeout
//   S_START | confirming the start bit at the half-bit point
//   S_DATA  | sampling 8 data bits, LSB first, one per bit period
//   S_STOP  | sampling the stop bit; stores byte, publishes triple or errors
module receptor_serial #(
  parameter int CLKS_PER_BIT = 16,
  parameter int GAP_CLKS     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  receptor_serial_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int GW = $clog2(GAP_CLKS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CLKS);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          rx_s_q, rx_s_d;
  logic          rx_prev_q, rx_prev_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    sh0_q, sh0_d;
  logic [7:0]    sh1_q, sh1_d;
  logic [1:0]    indice_q, indice_d;
  logic [7:0]    x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic [7:0]    z_q, z_d;
  logic          dv_q, dv_d;
  logic          err_q, err_d;

  always_comb begin
    state_d   = state_q;
    sync1_d   = bus.canal_serial;
    rx_s_d    = sync1_q;
    rx_prev_d = rx_s_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shift_d   = shift_q;
    sh0_d     = sh0_q;
    sh1_d     = sh1_q;
    indice_d  = indice_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    dv_d      = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q && rx_prev_q) begin
          state_d   = S_START;
          clk_cnt_d = '0;
          gap_cnt_d = '0;
        end else if (rx_s_q && gap_cnt_q != GAP_MAX) begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
        // A group left incomplete for too long is abandoned so the next
        // frame is taken as x again.
        if (gap_cnt_q == GAP_MAX && indice_q != 2'd0) begin
          indice_d = 2'd0;
          sh0_d    = '0;
          sh1_d    = '0;
        end
      end

      S_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          if (!rx_s_q) begin
            state_d   = S_DATA;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          clk_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      S_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          // Leaving at mid stop bit lets IDLE see the next start edge even
          // when frames are sent with no idle between them.
          state_d = S_IDLE;
          if (rx_s_q) begin
            if (indice_q == 2'd2) begin
              x_d      = sh0_q;
              y_d      = sh1_q;
              z_d      = shift_q;
              dv_d     = 1'b1;
              indice_d = 2'd0;
            end else begin
              if (indice_q == 2'd0) sh0_d = shift_q;
              else                  sh1_d = shift_q;
              indice_d = indice_q + 2'd1;
            end
          end else begin
            err_d    = 1'b1;
            indice_d = 2'd0;
            sh0_d    = '0;
            sh1_d    = '0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      shift_q   <= '0;
      sh0_q     <= '0;
      sh1_q     <= '0;
      indice_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      shift_q   <= shift_d;
      sh0_q     <= sh0_d;
      sh1_q     <= sh1_d;
      indice_q  <= indice_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      dv_q      <= dv_d;
      err_q     <= err_d;
    end
  end

  assign bus.x             = x_q;
  assign bus.y             = y_q;
  assign bus.z             = z_q;
  assign bus.datos_validos = dv_q;
  assign bus.error_trama   = err_q;
  assign bus.indice        = indice_q;

endmodule

// File: tb/tb_receptor_serial.sv
// tb_receptor_serial
//   Drives frames onto the serial line and compares the receiver against a
//   frame-level model: good frames fill a pending byte list, the third one
//   publishes a triple, a bad stop bit clears the list and counts an error,
//   and a long enough idle gap clears the list.
module tb_receptor_serial;

  localparam int CPB      = 16;
  localparam int GAP      = 64;
  localparam int IDLE_TMO = 80;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  receptor_serial_if bus_if ();

  receptor_serial #(.CLKS_PER_BIT(CPB), .GAP_CLKS(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // frame-level reference model
  logic [7:0]  pend[$];
  logic [23:0] exp_q[$];
  logic [23:0] last_xyz = '0;
  int          dv_exp   = 0;
  int          err_exp  = 0;
  int          idle_run = 0;

  function automatic void model_frame(input logic [7:0] b, input bit ok);
    idle_run = 0;
    if (ok) begin
      pend.push_back(b);
      if (pend.size() == 3) begin
        last_xyz = {pend[0], pend[1], pend[2]};
        exp_q.push_back(last_xyz);
        dv_exp++;
        pend.delete();
      end
    end else begin
      err_exp++;
      pend.delete();
    end
  endfunction

  // monitor
  int          dv_cnt  = 0;
  int          err_cnt = 0;
  logic [23:0] prev_xyz = '0;
  logic [23:0] cur_xyz;
  logic [23:0] e_xyz;

  always @(posedge clk) begin
    #1;
    cur_xyz = {bus_if.x, bus_if.y, bus_if.z};
    if (rst_n) begin
      if (bus_if.datos_validos) begin
        dv_cnt++;
        chk("dv_err_excl", {31'd0, bus_if.error_trama}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("dv_spurious", 32'd1, 32'd0);
        end else begin
          e_xyz = exp_q.pop_front();
          chk("xyz_on_dv", {8'd0, cur_xyz}, {8'd0, e_xyz});
        end
      end else begin
        chk("xyz_hold", {8'd0, cur_xyz}, {8'd0, prev_xyz});
      end
      if (bus_if.error_trama) err_cnt++;
    end
    prev_xyz = cur_xyz;
  end

  // stimulus helpers
  task automatic idle(input int n);
    bus_if.canal_serial = 1'b1;
    repeat (n) @(negedge clk);
    idle_run += n;
    if (idle_run >= IDLE_TMO) pend.delete();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok);
    model_frame(b, ok);
    bus_if.canal_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus_if.canal_serial = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus_if.canal_serial = ok;
    repeat (CPB) @(negedge clk);
    // a bad stop leaves the line low; it must rise before the next start
    if (!ok) idle(20);
  endtask

  task automatic send_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_frame(a, 1'b1);
    send_frame(b, 1'b1);
    send_frame(c, 1'b1);
  endtask

  task automatic glitch(input int n);
    idle_run = 0;
    bus_if.canal_serial = 1'b0;
    repeat (n) @(negedge clk);
    idle(30);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pend.delete();
    exp_q.delete();
    last_xyz = '0;
    idle_run = 0;
  endtask

  task automatic end_checks(input string tag);
    @(posedge clk);
    #2;
    chk({tag, "_indice"}, {30'd0, bus_if.indice}, pend.size());
    chk({tag, "_xyz"}, {8'd0, bus_if.x, bus_if.y, bus_if.z}, {8'd0, last_xyz});
    chk({tag, "_dv_cnt"}, dv_cnt, dv_exp);
    chk({tag, "_err_cnt"}, err_cnt, err_exp);
    chk({tag, "_pending_dv"}, exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit         ok;
    bus_if.canal_serial = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_x", {24'd0, bus_if.x}, 32'd0);
    chk("rst_y", {24'd0, bus_if.y}, 32'd0);
    chk("rst_z", {24'd0, bus_if.z}, 32'd0);
    chk("rst_dv", {31'd0, bus_if.datos_validos}, 32'd0);
    chk("rst_err", {31'd0, bus_if.error_trama}, 32'd0);
    chk("rst_indice", {30'd0, bus_if.indice}, 32'd0);

    idle(1000);
    end_checks("idle");

    send_triple(8'h5A, 8'hC3, 8'h81);
    idle(20);
    end_checks("b2b");

    glitch(4);
    end_checks("glitch_idle");
    send_triple(8'h01, 8'h02, 8'h03);
    idle(20);
    end_checks("glitch_after");

    send_frame(8'h3C, 1'b1);
    idle(10);
    glitch(4);
    chk("glitch_mid_indice", {30'd0, bus_if.indice}, 32'd1);
    send_frame(8'h4D, 1'b1);
    send_frame(8'h5E, 1'b1);
    idle(20);
    end_checks("glitch_mid");

    send_triple(8'h10, 8'h20, 8'h30);
    send_frame(8'h99, 1'b1);
    send_frame(8'h98, 1'b0);
    chk("frm_err_indice", {30'd0, bus_if.indice}, 32'd0);
    end_checks("frm_err");
    send_frame(8'h97, 1'b1);
    idle(100);
    end_checks("frm_err_tail");
    send_triple(8'hAA, 8'hBB, 8'hCC);
    idle(20);
    end_checks("frm_err_after");

    send_frame(8'h77, 1'b1);
    idle(20);
    chk("tmo_before_indice", {30'd0, bus_if.indice}, 32'd1);
    idle(60);
    end_checks("tmo");
    send_triple(8'h11, 8'h22, 8'h33);
    idle(20);
    end_checks("tmo_after");

    send_frame(8'h12, 1'b1);
    b = 8'hE5;
    bus_if.canal_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus_if.canal_serial = b[i];
      repeat (CPB) @(negedge clk);
    end
    pulse_reset();
    idle(100);
    end_checks("rst_mid");
    send_triple(8'h44, 8'h55, 8'h66);
    idle(20);
    end_checks("rst_mid_after");

    for (int k = 0; k < 48; k++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 9) != 0);
      send_frame(b, ok);
      if ($urandom_range(0, 5) == 0) idle(int'($urandom_range(100, 150)));
      else                           idle(int'($urandom_range(0, 30)));
    end
    idle(20);
    end_checks("random");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
